// File: rtl/seq_gen_serial.sv
`default_nettype none
// ============================================================================
//  Module   : seq_gen_serial
//  Brief    : Serial bit-pattern generator. Emits a latched pattern MSB-first
//             (starting at bit len-1), repeated reps times with optional idle
//             gap cycles between repetitions, gated by an advance enable.
//  Revision : 1.0  initial release
// ============================================================================
module seq_gen_serial #(
  parameter int W  = 16,  // maximum pattern width in bits
  parameter int LW = 5    // width of len; 2**LW must exceed W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [W-1:0]  pattern,
  input  logic [LW-1:0] len,
  input  logic [3:0]    reps,
  input  logic [3:0]    gap,
  input  logic          en,
  output logic          out,
  output logic          out_valid,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [LW-1:0] C_LEN_MAX = LW'(W);
  localparam logic [LW-1:0] C_ONE     = LW'(1);

  state_t        state_q,     state_d;
  logic [W-1:0]  pat_q,       pat_d;
  logic [LW-1:0] len_q,       len_d;
  logic [LW-1:0] idx_q,       idx_d;
  logic [3:0]    reps_q,      reps_d;
  logic [3:0]    gap_cfg_q,   gap_cfg_d;
  logic [3:0]    gap_cnt_q,   gap_cnt_d;
  logic          out_q,       out_d;
  logic          out_valid_q, out_valid_d;
  logic          done_q,      done_d;

  logic [LW-1:0] w_len_clamp;

  // Select one pattern bit by a runtime index without a width-mismatched part-select
  function automatic logic bit_at(input logic [W-1:0] p, input logic [LW-1:0] i);
    logic [W-1:0] s;
    s = p >> i;
    return s[0];
  endfunction

  // Next-state and next-output computation for the IDLE/SHIFT/GAP sequencer
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    len_d       = len_q;
    idx_d       = idx_q;
    reps_d      = reps_q;
    gap_cfg_d   = gap_cfg_q;
    gap_cnt_d   = gap_cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    w_len_clamp = (len > C_LEN_MAX) ? C_LEN_MAX : len;

    case (state_q)
      IDLE: begin
        out_d       = 1'b0;
        out_valid_d = 1'b0;
        if (load_valid) begin
          pat_d     = pattern;
          len_d     = w_len_clamp;
          gap_cfg_d = gap;
          reps_d    = (reps == 4'd0) ? 4'd1 : reps;
          if (w_len_clamp != '0) begin
            state_d     = SHIFT;
            idx_d       = w_len_clamp - C_ONE;
            out_d       = bit_at(pattern, w_len_clamp - C_ONE);
            out_valid_d = 1'b1;
          end else begin
            // Empty job: nothing to shift, just acknowledge completion
            done_d = 1'b1;
          end
        end
      end

      SHIFT: begin
        if (en) begin
          if (idx_q != '0) begin
            idx_d = idx_q - C_ONE;
            out_d = bit_at(pat_q, idx_q - C_ONE);
          end else if (reps_q > 4'd1) begin
            reps_d = reps_q - 4'd1;
            if (gap_cfg_q != 4'd0) begin
              state_d     = GAP;
              gap_cnt_d   = gap_cfg_q;
              out_d       = 1'b0;
              out_valid_d = 1'b0;
            end else begin
              // Zero gap: restart the pattern with no bubble
              idx_d = len_q - C_ONE;
              out_d = bit_at(pat_q, len_q - C_ONE);
            end
          end else begin
            state_d     = IDLE;
            out_d       = 1'b0;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
          end
        end
      end

      GAP: begin
        if (en) begin
          // gap_cnt holds the idle cycles remaining, including the current one
          if (gap_cnt_q > 4'd1) begin
            gap_cnt_d = gap_cnt_q - 4'd1;
          end else begin
            state_d     = SHIFT;
            idx_d       = len_q - C_ONE;
            out_d       = bit_at(pat_q, len_q - C_ONE);
            out_valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        out_d       = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      reps_q      <= '0;
      gap_cfg_q   <= '0;
      gap_cnt_q   <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      reps_q      <= reps_d;
      gap_cfg_q   <= gap_cfg_d;
      gap_cnt_q   <= gap_cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q == SHIFT) || (state_q == GAP);
  assign out        = out_q;
  assign out_valid  = out_valid_q;
  assign done       = done_q;

endmodule
`default_nettype wire
